counter_gen: RTL

Parametrised successor to the basic free-running counter: up/down counter with runtime limit, wrap or saturate mode, synchronous clear/load, enable and a built-in clock-enable prescaler. Provides terminal-count and wrap pulses plus a sticky overflow flag. Intended as the general-purpose timer/counter primitive for the digital examples and for the blocks built on them.

---
 rtl/counter_pkg.sv | 40 ++++
 rtl/counter_prescale.sv | 49 ++++
 rtl/counter_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter_gen timer/counter primitive.
//   DIR_UP / DIR_DOWN     : encodings of the dir_i input
//   MODE_WRAP / MODE_SAT  : encodings of the mode_i input
//   action_e              : what the counter register does on a given edge
//   select_action()       : resolves clear > load > step > hold
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_STEP  = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } action_e;

    // Clear dominates load, load dominates a prescaler tick.
    function automatic action_e select_action(input logic clear,
                                              input logic load,
                                              input logic tick);
        action_e act;
        if (clear) begin
            act = ACT_CLEAR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (tick) begin
            act = ACT_STEP;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/counter_prescale.sv
// -----------------------------------------------------------------------------
// counter_prescale
// Clock-enable prescaler for counter_gen. Produces one tick every presc_i+1
// enabled cycles; with presc_i = 0 the tick simply follows en_i.
//   clk_i    in   clock, rising edge
//   reset_ni in   asynchronous active-low reset
//   clear_i  in   synchronous restart of the phase count
//   en_i     in   phase advances only while high
//   presc_i  in   divide-minus-one
//   tick_o   out  combinational step strobe
// -----------------------------------------------------------------------------
module counter_prescale #(
    parameter int PWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [PWIDTH-1:0] presc_i,
    output logic              tick_o
);

    logic [PWIDTH-1:0] phase_reg;
    logic [PWIDTH-1:0] phase_next;

    // ">=" rather than "==" so that lowering presc_i below the current phase
    // produces a tick immediately instead of running the phase round.
    assign tick_o = en_i && (phase_reg >= presc_i);

    always_comb begin
        phase_next = phase_reg;
        if (clear_i) begin
            phase_next = '0;
        end else if (en_i) begin
            // The phase never exceeds presc_i while enabled, so the increment
            // cannot roll over.
            phase_next = tick_o ? '0 : phase_reg + PWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/counter_gen.sv
// -----------------------------------------------------------------------------
// counter_gen
// General-purpose up/down counter with runtime inclusive upper limit, wrap or
// saturate behaviour, synchronous clear/load, enable and prescaler.
//   clk_i       in   clock, rising edge
//   reset_ni    in   asynchronous active-low reset
//   clear_i     in   synchronous clear of counter, prescaler and flags
//   load_i      in   synchronous load of load_val_i
//   load_val_i  in   value to load (may exceed limit_i)
//   en_i        in   count enable
//   dir_i       in   1 = up, 0 = down
//   mode_i      in   0 = wrap, 1 = saturate
//   limit_i     in   inclusive upper bound (lower bound is 0)
//   presc_i     in   prescaler divide-minus-one
//   out_o       out  counter register
//   tc_o        out  pulse: last step landed on the terminal value
//   wrap_o      out  pulse: last step wrapped
//   sat_o       out  level: saturate mode and sitting on the bound for dir_i
//   ovf_o       out  sticky overflow/underflow
// -----------------------------------------------------------------------------
module counter_gen
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              mode_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic [PWIDTH-1:0] presc_i,
    output logic [WIDTH-1:0]  out_o,
    output logic              tc_o,
    output logic              wrap_o,
    output logic              sat_o,
    output logic              ovf_o
);

    logic              tick;
    logic              presc_clear;
    action_e           action;

    logic [WIDTH-1:0]  out_reg;
    logic [WIDTH-1:0]  out_next;
    logic              tc_reg;
    logic              tc_next;
    logic              wrap_reg;
    logic              wrap_next;
    logic              ovf_reg;
    logic              ovf_next;

    // Comparisons against the current value, shared by both directions.
    logic              at_or_above_limit;
    logic              above_limit;
    logic              at_limit;
    logic              at_zero;
    logic [WIDTH-1:0]  value_inc;
    logic [WIDTH-1:0]  value_dec;

    // A load also restarts the prescaler so the first step after a load is a
    // full prescaler period away.
    assign presc_clear = clear_i | load_i;

    counter_prescale #(
        .PWIDTH (PWIDTH)
    ) u_prescale (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (presc_clear),
        .en_i     (en_i),
        .presc_i  (presc_i),
        .tick_o   (tick)
    );

    assign action            = select_action(clear_i, load_i, tick);
    assign at_or_above_limit = (out_reg >= limit_i);
    assign above_limit       = (out_reg > limit_i);
    assign at_limit          = (out_reg == limit_i);
    assign at_zero           = (out_reg == '0);
    assign value_inc         = out_reg + WIDTH'(1);
    assign value_dec         = out_reg - WIDTH'(1);

    always_comb begin
        // Pulses are single-cycle: anything not re-asserting them drops them.
        out_next  = out_reg;
        tc_next   = 1'b0;
        wrap_next = 1'b0;
        ovf_next  = ovf_reg;

        unique case (action)
            ACT_CLEAR: begin
                out_next = '0;
                ovf_next = 1'b0;
            end

            ACT_LOAD: begin
                out_next = load_val_i;
            end

            ACT_STEP: begin
                if (dir_i == DIR_UP) begin
                    if (!at_or_above_limit) begin
                        out_next = value_inc;
                        tc_next  = (value_inc == limit_i);
                    end else if (mode_i == MODE_WRAP) begin
                        // Wrapping from (or past) the top never counts as
                        // reaching the terminal value.
                        out_next  = '0;
                        wrap_next = 1'b1;
                        ovf_next  = 1'b1;
                    end else begin
                        // Saturating: a value loaded above the limit is pulled
                        // back to the limit without flagging overflow; only a
                        // step attempted while already at the limit does.
                        out_next = limit_i;
                        tc_next  = 1'b1;
                        if (at_limit) begin
                            ovf_next = 1'b1;
                        end
                    end
                end else begin
                    if (above_limit) begin
                        // Out-of-range value re-enters the window at the top.
                        out_next = limit_i;
                        tc_next  = (limit_i == '0);
                    end else if (!at_zero) begin
                        out_next = value_dec;
                        tc_next  = (value_dec == '0);
                    end else if (mode_i == MODE_WRAP) begin
                        out_next  = limit_i;
                        wrap_next = 1'b1;
                        ovf_next  = 1'b1;
                    end else begin
                        // Saturated hold at zero repeats the terminal pulse.
                        tc_next  = 1'b1;
                        ovf_next = 1'b1;
                    end
                end
            end

            default: begin
                // ACT_HOLD: defaults above keep the value and drop pulses.
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_reg  <= '0;
            tc_reg   <= 1'b0;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            out_reg  <= out_next;
            tc_reg   <= tc_next;
            wrap_reg <= wrap_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign out_o  = out_reg;
    assign tc_o   = tc_reg;
    assign wrap_o = wrap_reg;
    assign ovf_o  = ovf_reg;

    // Live view of the current inputs, so a change of dir_i or mode_i shows
    // immediately even though it only affects the next step.
    assign sat_o = (mode_i == MODE_SAT) &&
                   (((dir_i == DIR_UP) && at_or_above_limit) ||
                    ((dir_i == DIR_DOWN) && at_zero));

endmodule
